// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with a one-entry skid buffer, a registered in_ready,
// a bubble-inserting flush and a saturating stall-cycle counter.
module pipe_stage_skid #(
   parameter int unsigned         DATA_W = 64,
   parameter logic [DATA_W-1:0]   BUBBLE = '0,
   parameter int unsigned         CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_clr
);

   // Encoding equals the number of held entries, so occupancy is the state itself.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   main_q, main_d;
   logic [DATA_W-1:0]   skid_q, skid_d;
   logic                in_ready_q;
   logic [CNT_W-1:0]    stall_q, stall_d;
   logic                in_xfer;

   assign in_xfer   = in_valid & in_ready_q;
   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_q;
   assign stall_cnt = stall_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      unique case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               main_d  = in_data;
               state_d = FULL;
            end
         end
         FULL: begin
            if (out_ready && in_xfer) begin
               main_d = in_data;
            end else if (out_ready) begin
               main_d  = BUBBLE;
               state_d = EMPTY;
            end else if (in_xfer) begin
               skid_d  = in_data;
               state_d = SKID;
            end
         end
         SKID: begin
            if (out_ready) begin
               main_d  = skid_q;
               skid_d  = BUBBLE;
               state_d = FULL;
            end
         end
         default: begin
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
            state_d = EMPTY;
         end
      endcase

      if (flush) begin
         main_d  = BUBBLE;
         skid_d  = BUBBLE;
         state_d = EMPTY;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (stall_clr) begin
         stall_d = '0;
      end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: payload registers are reset too, because out_data must read BUBBLE, never X, after reset.
      if (rst) begin
         state_q    <= EMPTY;
         main_q     <= BUBBLE;
         skid_q     <= BUBBLE;
         in_ready_q <= 1'b1;
         stall_q    <= '0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= (state_d != SKID);
         stall_q    <= stall_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: scenario tasks plus an in-order
// scoreboard that pairs every accepted input with its delivered output.
module tb_pipe_stage_skid;

   localparam int unsigned       DATA_W = 16;
   localparam int unsigned       CNT_W  = 3;
   localparam logic [DATA_W-1:0] BUBBLE = 16'h0F0F;

   logic              clk = 1'b0;
   logic              rst, flush, in_valid, out_ready, stall_clr;
   logic [DATA_W-1:0] in_data;
   logic              in_ready, out_valid;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  stall_cnt;

   int total = 0;
   int bad   = 0;
   logic [DATA_W-1:0] sb[$];

   pipe_stage_skid #(.DATA_W(DATA_W), .BUBBLE(BUBBLE), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // Scoreboard: inputs and outputs are stable at the falling edge.
   always @(negedge clk) begin
      logic [DATA_W-1:0] exp_v;
      if (rst) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL sb_underflow got=%h exp=<none>", out_data);
            end else begin
               exp_v = sb.pop_front();
               if (out_data !== exp_v) begin
                  bad++;
                  $display("FAIL sb_data got=%h exp=%h", out_data, exp_v);
               end
            end
         end
         if (flush) sb.delete();
         else if (in_valid && in_ready) sb.push_back(in_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 0; flush = 0; in_valid = 0; out_ready = 0; stall_clr = 0; in_data = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
      total++; if (in_ready  !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      total++; if (out_data  !== BUBBLE) begin bad++; $display("FAIL rst_out_data got=%h exp=%h", out_data, BUBBLE); end
      total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rst_occupancy got=%0d exp=0", occupancy); end
      total++; if (stall_cnt !== 3'd0) begin bad++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
   endtask

   task automatic test_stream();
      out_ready = 1;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1; in_data = DATA_W'(i);
         tick();
         total++; if (out_valid !== 1'b1 || out_data !== DATA_W'(i)) begin bad++; $display("FAIL stream_out got=%b/%h exp=1/%h", out_valid, out_data, DATA_W'(i)); end
         total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL stream_occ got=%0d exp=1", occupancy); end
         total++; if (stall_cnt !== 3'd0) begin bad++; $display("FAIL stream_stall got=%0d exp=0", stall_cnt); end
      end
      in_valid = 0;
      tick();
      total++; if (out_valid !== 1'b0 || out_data !== BUBBLE) begin bad++; $display("FAIL stream_end got=%b/%h exp=0/%h", out_valid, out_data, BUBBLE); end
   endtask

   task automatic test_backpressure();
      out_ready = 0; in_valid = 1; in_data = 16'h000A;
      tick();
      in_data = 16'h000B;
      tick();
      total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL bp_occ2 got=%0d exp=2", occupancy); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
      total++; if (out_data !== 16'h000A) begin bad++; $display("FAIL bp_head got=%h exp=000a", out_data); end
      total++; if (stall_cnt !== 3'd1) begin bad++; $display("FAIL bp_stall got=%0d exp=1", stall_cnt); end
      in_data = 16'h000C;
      tick();
      total++; if (occupancy !== 2'd2 || out_data !== 16'h000A) begin bad++; $display("FAIL bp_hold got=%0d/%h exp=2/000a", occupancy, out_data); end
      out_ready = 1;
      tick();
      total++; if (out_data !== 16'h000B || occupancy !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_unskid got=%h/%0d/%b exp=000b/1/1", out_data, occupancy, in_ready); end
      tick();
      total++; if (out_data !== 16'h000C || occupancy !== 2'd1) begin bad++; $display("FAIL bp_third got=%h/%0d exp=000c/1", out_data, occupancy); end
      in_valid = 0;
      tick();
      total++; if (occupancy !== 2'd0 || sb.size() != 0) begin bad++; $display("FAIL bp_drain got=%0d/%0d exp=0/0", occupancy, sb.size()); end
      stall_clr = 1;
      tick();
      stall_clr = 0;
   endtask

   task automatic test_flush_skid();
      out_ready = 0; in_valid = 1; in_data = 16'h0011;
      tick();
      in_data = 16'h0022;
      tick();
      total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL fl_occ2 got=%0d exp=2", occupancy); end
      flush = 1; in_data = 16'h0033;
      tick();
      flush = 0; in_valid = 0;
      total++; if (out_valid !== 1'b0 || out_data !== BUBBLE) begin bad++; $display("FAIL fl_out got=%b/%h exp=0/%h", out_valid, out_data, BUBBLE); end
      total++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL fl_state got=%0d/%b exp=0/1", occupancy, in_ready); end
      total++; if (stall_cnt !== 3'd2) begin bad++; $display("FAIL fl_stall_kept got=%0d exp=2", stall_cnt); end
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_ghost got=%b/%h exp=0", out_valid, out_data); end
      end
      stall_clr = 1;
      tick();
      stall_clr = 0;
   endtask

   task automatic test_stall_counter();
      out_ready = 0; in_valid = 1; in_data = 16'h0044;
      tick();
      in_valid = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         total++; if (stall_cnt !== CNT_W'((i > 7) ? 7 : i)) begin bad++; $display("FAIL stall_cnt_%0d got=%0d exp=%0d", i, stall_cnt, (i > 7) ? 7 : i); end
      end
      stall_clr = 1;
      tick();
      stall_clr = 0;
      total++; if (stall_cnt !== 3'd0) begin bad++; $display("FAIL stall_clr got=%0d exp=0", stall_cnt); end
      tick();
      total++; if (stall_cnt !== 3'd1) begin bad++; $display("FAIL stall_resume got=%0d exp=1", stall_cnt); end
      out_ready = 1;
      tick();
      total++; if (stall_cnt !== 3'd1 || out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%0d/%b exp=1/0", stall_cnt, out_valid); end
   endtask

   task automatic test_reset_mid();
      out_ready = 0; in_valid = 1; in_data = 16'h0055;
      tick();
      in_data = 16'h0066;
      tick();
      total++; if (occupancy !== 2'd2 || stall_cnt === 3'd0) begin bad++; $display("FAIL rm_setup got=%0d/%0d exp=2/nonzero", occupancy, stall_cnt); end
      rst = 1; flush = 1; stall_clr = 1; out_ready = 1; in_data = 16'h0077;
      tick();
      rst = 0; flush = 0; stall_clr = 0; in_valid = 0; out_ready = 0;
      total++; if (out_valid !== 1'b0 || out_data !== BUBBLE || in_ready !== 1'b1) begin bad++; $display("FAIL rm_out got=%b/%h/%b exp=0/%h/1", out_valid, out_data, in_ready, BUBBLE); end
      total++; if (occupancy !== 2'd0 || stall_cnt !== 3'd0) begin bad++; $display("FAIL rm_state got=%0d/%0d exp=0/0", occupancy, stall_cnt); end
      in_valid = 1; in_data = 16'h0088; out_ready = 1;
      tick();
      in_valid = 0;
      total++; if (out_valid !== 1'b1 || out_data !== 16'h0088) begin bad++; $display("FAIL rm_first got=%b/%h exp=1/0088", out_valid, out_data); end
      tick();
   endtask

   task automatic test_drain();
      out_ready = 1; in_valid = 1; in_data = 16'h0005;
      tick();
      in_valid = 0;
      total++; if (out_valid !== 1'b1 || out_data !== 16'h0005) begin bad++; $display("FAIL dr_one got=%b/%h exp=1/0005", out_valid, out_data); end
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (out_valid !== 1'b0 || out_data !== BUBBLE) begin bad++; $display("FAIL dr_empty got=%b/%h exp=0/%h", out_valid, out_data, BUBBLE); end
      end
   endtask

   task automatic test_back_to_back();
      int budget;
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = DATA_W'($urandom);
         tick();
         total++; if (out_valid !== (occupancy != 2'd0) || in_ready !== (occupancy != 2'd2)) begin bad++; $display("FAIL b2b_flags got=%b/%b/%0d", out_valid, in_ready, occupancy); end
      end
      in_valid = 0; out_ready = 1;
      budget = 0;
      while (occupancy != 2'd0 && budget < 10) begin
         tick();
         budget++;
      end
      total++; if (occupancy !== 2'd0 || sb.size() != 0) begin bad++; $display("FAIL b2b_drain got=%0d/%0d exp=0/0", occupancy, sb.size()); end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_stream();
      test_backpressure();
      test_flush_skid();
      test_stall_counter();
      test_reset_mid();
      test_drain();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
